// File: rtl/si_tag_lane_arbiter_if.sv
// Lane-side request bundle for si_tag_lane_arbiter: packed per-lane tag/wrap_count plus
// valid/ready. The lane sources drive the master modport; the arbiter uses the slave modport.
interface si_tag_lane_arbiter_if #(
    parameter int unsigned LANES = 4
) ();

    logic [32*LANES-1:0] s_tag;
    logic [32*LANES-1:0] s_wrap_count;
    logic [LANES-1:0]    s_valid;
    logic [LANES-1:0]    s_ready;

    modport master (
        output s_tag,
        output s_wrap_count,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_tag,
        input  s_wrap_count,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/si_tag_lane_arbiter.sv
// Round-robin arbiter that time-shares one tag converter between LANES tag streams and
// delay-matches the granted lane index so each converted tag leaves tagged with its source.
module si_tag_lane_arbiter #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned LANE_W       = 2,
    parameter int unsigned CONV_LATENCY = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    si_tag_lane_arbiter_if.slave  lane_if,
    output logic [31:0]           conv_tag_o,
    output logic [31:0]           conv_wrap_count_o,
    input  logic                  conv_valid_tag_i,
    output logic                  m_valid_o,
    output logic [LANE_W-1:0]     m_lane_o,
    output logic                  busy_o
);

    logic [31:0]       tag_lane  [LANES];
    logic [31:0]       wrap_lane [LANES];

    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic              win_found;
    logic [LANE_W-1:0] win_idx;
    logic              xfer;

    logic [31:0]       conv_tag_q, conv_tag_d;
    logic [31:0]       conv_wrap_q, conv_wrap_d;

    logic [CONV_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [LANE_W-1:0]       pipe_lane_q [CONV_LATENCY];
    logic [LANE_W-1:0]       pipe_lane_d [CONV_LATENCY];

    logic              out_vld_q, out_vld_d;
    logic [LANE_W-1:0] out_lane_q, out_lane_d;

    for (genvar g = 0; g < LANES; g++) begin : gen_unpack
        assign tag_lane[g]  = lane_if.s_tag[32*g +: 32];
        assign wrap_lane[g] = lane_if.s_wrap_count[32*g +: 32];
    end

    // First requesting lane at or after ptr, wrapping modulo LANES (not 2**LANE_W).
    always_comb begin
        int unsigned       cand;
        logic [LANE_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= LANES) begin
                cand = cand - LANES;
            end
            cand_idx = LANE_W'(cand);
            if (!win_found && lane_if.s_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign xfer = win_found & enable_i & rst_ni;

    always_comb begin
        lane_if.s_ready = '0;
        if (xfer) begin
            lane_if.s_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            if (32'(win_idx) == LANES - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + LANE_W'(1);
            end
        end
    end

    // Idle cycles feed tag 0 (event_type 00) so the converter emits nothing for the bubble.
    always_comb begin
        conv_tag_d  = '0;
        conv_wrap_d = conv_wrap_q;
        if (xfer) begin
            conv_tag_d  = tag_lane[win_idx];
            conv_wrap_d = wrap_lane[win_idx];
        end
    end

    always_comb begin
        pipe_vld_d  = '0;
        pipe_lane_d = '{default: '0};
        pipe_vld_d[0]  = xfer;
        pipe_lane_d[0] = xfer ? win_idx : '0;
        for (int unsigned s = 1; s < CONV_LATENCY; s++) begin
            pipe_vld_d[s]  = pipe_vld_q[s-1];
            pipe_lane_d[s] = pipe_lane_q[s-1];
        end
    end

    // The converter output appears one cycle after the last pipe stage, so one more
    // register lines the lane tag up with valid_tag; it is not counted in busy.
    always_comb begin
        out_vld_d  = pipe_vld_q[CONV_LATENCY-1];
        out_lane_d = pipe_lane_q[CONV_LATENCY-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            conv_tag_q  <= '0;
            conv_wrap_q <= '0;
            pipe_vld_q  <= '0;
            pipe_lane_q <= '{default: '0};
            out_vld_q   <= 1'b0;
            out_lane_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            conv_tag_q  <= conv_tag_d;
            conv_wrap_q <= conv_wrap_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_lane_q <= pipe_lane_d;
            out_vld_q   <= out_vld_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign conv_tag_o        = conv_tag_q;
    assign conv_wrap_count_o = conv_wrap_q;
    assign m_valid_o         = out_vld_q & conv_valid_tag_i;
    assign m_lane_o          = out_lane_q;
    assign busy_o            = |pipe_vld_q;

endmodule
